hdc_am_classifier: RTL and testbench

Associative-memory classifier that turns window hypervectors into seizure/non-seizure labels; it is the decode end of the HDC pipeline. It accepts one window HV per handshake from the window encoder. It computes the Hamming distance to every stored class prototype, streaming CHUNK bits per cycle. It then emits the label of the nearest prototype with its distance. Prototypes are loaded chunk-by-chunk through a write port, from training or a host.

---
 rtl/hdc_pkg.sv | 28 ++
 rtl/hamming_chunk.sv | 29 ++
 rtl/hdc_am_classifier.sv | 146 ++++++++++++++
 tb/tb_hdc_am_classifier.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/hdc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hdc_pkg
// Brief    : Shared HDC constants, sizing helpers and controller state enum.
// Revision : 1.0 - initial release
// ============================================================================
package hdc_pkg;

   localparam int DIMENSIONS_DEF = 10000;
   localparam int CHUNK_DEF      = 64;

   function automatic int num_chunks(input int dims, input int chunk);
      return (dims + chunk - 1) / chunk;
   endfunction

   function automatic int dist_w(input int dims);
      return $clog2(dims + 1);
   endfunction

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      COMPARE = 2'd2,
      HOLD    = 2'd3
   } am_state_t;

endpackage
`default_nettype wire

// File: rtl/hamming_chunk.sv
`default_nettype none
// ============================================================================
// Module   : hamming_chunk
// Brief    : Masked XOR of two chunks followed by a population count.
// Revision : 1.0 - initial release
// ============================================================================
module hamming_chunk #(
   parameter int CHUNK = 64,
   parameter int OUT_W = $clog2(CHUNK + 1)
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic [CHUNK-1:0] mask,
   output logic [OUT_W-1:0] popcount
);

   logic [CHUNK-1:0] w_diff;

   assign w_diff = (a ^ b) & mask;

   always_comb begin
      popcount = '0;
      for (int k = 0; k < CHUNK; k++) begin
         popcount = popcount + OUT_W'(w_diff[k]);
      end
   end

endmodule
`default_nettype wire

// File: rtl/hdc_am_classifier.sv
`default_nettype none
// ============================================================================
// Module   : hdc_am_classifier
// Brief    : Associative memory; nearest-prototype label by chunked Hamming distance.
// Revision : 1.0 - initial release
// ============================================================================
module hdc_am_classifier
   import hdc_pkg::*;
#(
   parameter int DIMENSIONS  = DIMENSIONS_DEF,
   parameter int NUM_CLASSES = 2,
   parameter int CHUNK       = CHUNK_DEF,
   localparam int NUM_CHUNKS = num_chunks(DIMENSIONS, CHUNK),
   localparam int DIST_W     = dist_w(DIMENSIONS),
   localparam int CLS_W      = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
   localparam int ADDR_W     = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic [DIMENSIONS-1:0] window_hv,
   input  logic                  window_valid,
   output logic                  window_ready,
   input  logic                  proto_we,
   input  logic [CLS_W-1:0]      proto_class,
   input  logic [ADDR_W-1:0]     proto_addr,
   input  logic [CHUNK-1:0]      proto_wdata,
   output logic                  label_valid,
   input  logic                  label_ready,
   output logic [CLS_W-1:0]      label,
   output logic [DIST_W-1:0]     min_dist
);

   localparam int POP_W = $clog2(CHUNK + 1);
   localparam int QW    = NUM_CHUNKS * CHUNK;
   // Last chunk keeps only the bits that lie inside the hypervector.
   localparam logic [CHUNK-1:0] LAST_MASK = {CHUNK{1'b1}} >> (QW - DIMENSIONS);

   am_state_t          r_state, w_next_state;
   logic [QW-1:0]      r_query;
   logic [CHUNK-1:0]   r_proto [NUM_CLASSES][NUM_CHUNKS];
   logic [DIST_W-1:0]  r_acc   [NUM_CLASSES];
   logic [ADDR_W-1:0]  r_chunk_idx;
   logic [CLS_W-1:0]   r_label;
   logic [DIST_W-1:0]  r_min_dist;

   logic [CHUNK-1:0]   w_q_chunk;
   logic [CHUNK-1:0]   w_mask;
   logic [POP_W-1:0]   w_pop   [NUM_CLASSES];
   logic               w_last_chunk;
   logic               w_accept;
   logic               w_proto_wr;
   logic [CLS_W-1:0]   w_best_idx;
   logic [DIST_W-1:0]  w_best_dist;

   assign window_ready = (r_state == IDLE);
   assign label_valid  = (r_state == HOLD);
   assign label        = r_label;
   assign min_dist     = r_min_dist;

   assign w_accept     = (r_state == IDLE) && window_valid;
   assign w_proto_wr   = (r_state == IDLE) && proto_we
                         && ({1'b0, proto_class} < (CLS_W + 1)'(NUM_CLASSES))
                         && ({1'b0, proto_addr}  < (ADDR_W + 1)'(NUM_CHUNKS));
   assign w_last_chunk = (r_chunk_idx == ADDR_W'(NUM_CHUNKS - 1));
   assign w_q_chunk    = r_query[int'(r_chunk_idx) * CHUNK +: CHUNK];
   assign w_mask       = w_last_chunk ? LAST_MASK : {CHUNK{1'b1}};

   generate
      for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_class
         hamming_chunk #(
            .CHUNK (CHUNK),
            .OUT_W (POP_W)
         ) u_ham (
            .a        (w_q_chunk),
            .b        (r_proto[c][r_chunk_idx]),
            .mask     (w_mask),
            .popcount (w_pop[c])
         );
      end
   endgenerate

   // Storage and query register carry no reset; prototypes must survive nrst.
   always_ff @(posedge clk) begin
      if (w_accept) r_query <= QW'(window_hv);
      if (w_proto_wr) r_proto[proto_class][proto_addr] <= proto_wdata;
   end

   always_ff @(posedge clk) begin
      if (!nrst) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (window_valid) w_next_state = COMPUTE;
         COMPUTE: if (w_last_chunk) w_next_state = COMPARE;
         COMPARE: w_next_state = HOLD;
         HOLD:    if (label_ready)  w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Strict less-than keeps the lowest class index on ties.
   always_comb begin
      w_best_idx  = '0;
      w_best_dist = r_acc[0];
      for (int c = 1; c < NUM_CLASSES; c++) begin
         if (r_acc[c] < w_best_dist) begin
            w_best_dist = r_acc[c];
            w_best_idx  = CLS_W'(c);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_chunk_idx <= '0;
         r_label     <= '0;
         r_min_dist  <= '0;
         for (int c = 0; c < NUM_CLASSES; c++) r_acc[c] <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (window_valid) begin
                  r_chunk_idx <= '0;
                  for (int c = 0; c < NUM_CLASSES; c++) r_acc[c] <= '0;
               end
            end
            COMPUTE: begin
               r_chunk_idx <= r_chunk_idx + 1'b1;
               for (int c = 0; c < NUM_CLASSES; c++) begin
                  r_acc[c] <= r_acc[c] + DIST_W'(w_pop[c]);
               end
            end
            COMPARE: begin
               r_label    <= w_best_idx;
               r_min_dist <= w_best_dist;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hdc_am_classifier.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdc_am_classifier
// Brief    : Directed, table-driven bench for the associative-memory classifier.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdc_am_classifier;

   localparam int D   = 10000;
   localparam int CH  = 64;
   localparam int NC  = 157;
   localparam int LAT = 158;

   logic          clk = 1'b0;
   logic          nrst;
   logic [D-1:0]  window_hv;
   logic          window_valid;
   logic          window_ready;
   logic          proto_we;
   logic [0:0]    proto_class;
   logic [7:0]    proto_addr;
   logic [CH-1:0] proto_wdata;
   logic          label_valid;
   logic          label_ready;
   logic [0:0]    label;
   logic [13:0]   min_dist;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int ones;
      int exp_label;
      int exp_dist;
   } vec_t;

   vec_t vecs [7];

   always #5 clk = ~clk;

   hdc_am_classifier dut (
      .clk          (clk),
      .nrst         (nrst),
      .window_hv    (window_hv),
      .window_valid (window_valid),
      .window_ready (window_ready),
      .proto_we     (proto_we),
      .proto_class  (proto_class),
      .proto_addr   (proto_addr),
      .proto_wdata  (proto_wdata),
      .label_valid  (label_valid),
      .label_ready  (label_ready),
      .label        (label),
      .min_dist     (min_dist)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [D-1:0] make_ones(input int n);
      logic [D-1:0] hv;
      hv = '0;
      for (int i = 0; i < n; i++) hv[i] = 1'b1;
      return hv;
   endfunction

   task automatic write_proto(input int cls, input int addr, input logic [CH-1:0] data);
      proto_we    = 1'b1;
      proto_class = 1'(cls);
      proto_addr  = 8'(addr);
      proto_wdata = data;
      @(posedge clk); #1;
      proto_we    = 1'b0;
   endtask

   task automatic load_proto(input int cls, input logic [D-1:0] hv, input logic pad_ones);
      logic [NC*CH-1:0] ext;
      logic [CH-1:0]    chunk;
      ext = '0;
      ext[D-1:0] = hv;
      for (int a = 0; a < NC; a++) begin
         chunk = ext[a*CH +: CH];
         if (a == NC - 1 && pad_ones) chunk[CH-1:16] = '1;
         write_proto(cls, a, chunk);
      end
   endtask

   task automatic accept_query(input logic [D-1:0] hv);
      window_hv    = hv;
      window_valid = 1'b1;
      check("accept_ready", int'(window_ready), 1);
      @(posedge clk); #1;
      window_valid = 1'b0;
   endtask

   task automatic wait_result(input int start, output int lat);
      lat = start;
      while (!label_valid && lat < 400) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic consume(input string name, input int exp_label, input int exp_dist);
      check({name, "_label"}, int'(label), exp_label);
      check({name, "_dist"}, int'(min_dist), exp_dist);
      label_ready = 1'b1;
      @(posedge clk); #1;
      label_ready = 1'b0;
      check({name, "_ready_after"}, int'(window_ready), 1);
   endtask

   task automatic run_query(input string name, input logic [D-1:0] hv,
                            input int exp_label, input int exp_dist);
      int lat;
      accept_query(hv);
      wait_result(0, lat);
      check({name, "_latency"}, lat, LAT);
      consume(name, exp_label, exp_dist);
   endtask

   initial begin
      logic [D-1:0] tie_hv;
      int           lat;

      vecs[0] = '{ones: 3000,  exp_label: 0, exp_dist: 3000};
      vecs[1] = '{ones: 7000,  exp_label: 1, exp_dist: 3000};
      vecs[2] = '{ones: 0,     exp_label: 0, exp_dist: 0};
      vecs[3] = '{ones: 10000, exp_label: 1, exp_dist: 0};
      vecs[4] = '{ones: 5000,  exp_label: 0, exp_dist: 5000};
      vecs[5] = '{ones: 5001,  exp_label: 1, exp_dist: 4999};
      vecs[6] = '{ones: 4999,  exp_label: 0, exp_dist: 4999};

      nrst = 1'b0; window_hv = '0; window_valid = 1'b0; proto_we = 1'b0;
      proto_class = '0; proto_addr = '0; proto_wdata = '0; label_ready = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_window_ready", int'(window_ready), 1);
      check("rst_label_valid", int'(label_valid), 0);
      check("rst_label", int'(label), 0);
      check("rst_min_dist", int'(min_dist), 0);
      nrst = 1'b1;

      // Tie with padding: both prototypes equal the query, plus ones in the unused tail.
      for (int i = 0; i < D; i++) tie_hv[i] = (i % 3 == 0) || (i % 7 == 2);
      load_proto(0, tie_hv, 1'b1);
      load_proto(1, tie_hv, 1'b1);
      run_query("tie_pad", tie_hv, 0, 0);

      load_proto(0, make_ones(0), 1'b0);
      load_proto(1, make_ones(D), 1'b0);

      foreach (vecs[i]) begin
         run_query($sformatf("vec%0d", i), make_ones(vecs[i].ones),
                   vecs[i].exp_label, vecs[i].exp_dist);
      end

      // Write during COMPUTE must be dropped.
      accept_query(make_ones(3000));
      repeat (4) begin @(posedge clk); #1; end
      write_proto(0, 0, '1);
      wait_result(5, lat);
      check("gate_busy_latency", lat, LAT);
      consume("gate_busy", 0, 3000);

      // Same write in IDLE lowers class-0 distance by the 64 bits of chunk 0.
      write_proto(0, 0, '1);
      run_query("gate_idle", make_ones(3000), 0, 2936);
      write_proto(0, 0, '0);

      // Out-of-range address is ignored.
      write_proto(0, 200, '1);
      run_query("gate_addr", make_ones(3000), 0, 3000);

      // Backpressure with a pending second query.
      accept_query(make_ones(3000));
      wait_result(0, lat);
      check("bp_latency", lat, LAT);
      window_hv    = make_ones(7000);
      window_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         check("bp_label_valid", int'(label_valid), 1);
         check("bp_window_ready", int'(window_ready), 0);
         check("bp_label", int'(label), 0);
         check("bp_dist", int'(min_dist), 3000);
      end
      label_ready = 1'b1;
      @(posedge clk); #1;
      label_ready = 1'b0;
      check("bp_ready_after_E", int'(window_ready), 1);
      check("bp_valid_after_E", int'(label_valid), 0);
      @(posedge clk); #1;
      window_valid = 1'b0;
      check("bp_second_accepted", int'(window_ready), 0);
      wait_result(0, lat);
      check("bp2_latency", lat, LAT);
      consume("bp2", 1, 3000);

      // Reset in the middle of COMPUTE.
      accept_query(make_ones(3000));
      repeat (80) begin @(posedge clk); #1; end
      nrst = 1'b0;
      @(posedge clk); #1;
      nrst = 1'b1;
      check("midrst_window_ready", int'(window_ready), 1);
      check("midrst_label_valid", int'(label_valid), 0);
      check("midrst_label", int'(label), 0);
      check("midrst_dist", int'(min_dist), 0);
      run_query("after_rst", make_ones(7000), 1, 3000);
      run_query("after_rst_nom", make_ones(3000), 0, 3000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
